// File: rtl/processor_io_buffer_pkg.sv
// Shared configuration for the processor I/O buffer: packet widths,
// default FIFO depths and the packet types used on both sides.
package processor_config;

  localparam int INP_WIDTH = 8;
  localparam int OUT_WIDTH = 8;
  localparam int INP_DEPTH = 8;
  localparam int OUT_DEPTH = 8;

  typedef logic [INP_WIDTH-1:0] inp_pkt_t;
  typedef logic [OUT_WIDTH-1:0] out_pkt_t;

endpackage

// File: rtl/processor_io_buffer_if.sv
// Bundle of every handshake, data and status signal of the I/O buffer.
// slave is the buffer's view; master is the view of whatever surrounds it
// (user, network_source/sink and the flush/status controller).
interface processor_io_buffer_if #(
  parameter int INP_WIDTH = processor_config::INP_WIDTH,
  parameter int OUT_WIDTH = processor_config::OUT_WIDTH,
  parameter int INP_DEPTH = processor_config::INP_DEPTH,
  parameter int OUT_DEPTH = processor_config::OUT_DEPTH
);

  logic                         flush;
  logic                         inp_valid;
  logic [INP_WIDTH-1:0]         inp;
  logic                         inp_ready;
  logic                         src_valid;
  logic [INP_WIDTH-1:0]         src;
  logic                         src_ready;
  logic                         snk_valid;
  logic [OUT_WIDTH-1:0]         snk;
  logic                         snk_ready;
  logic                         out_valid;
  logic [OUT_WIDTH-1:0]         out;
  logic                         out_ready;
  logic [$clog2(INP_DEPTH):0]   inp_count;
  logic [$clog2(OUT_DEPTH):0]   out_count;
  logic                         out_afull;

  modport slave (
    input  flush,
    input  inp_valid, inp,
    output inp_ready,
    output src_valid, src,
    input  src_ready,
    input  snk_valid, snk,
    output snk_ready,
    output out_valid, out,
    input  out_ready,
    output inp_count, out_count, out_afull
  );

  modport master (
    output flush,
    output inp_valid, inp,
    input  inp_ready,
    input  src_valid, src,
    output src_ready,
    output snk_valid, snk,
    input  snk_ready,
    input  out_valid, out,
    output out_ready,
    input  inp_count, out_count, out_afull
  );

endinterface

// File: rtl/processor_io_buffer_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers. Ready/valid are
// derived only from the registered pointers, so a full FIFO refuses a push
// even when it is being popped in the same cycle (no ready->valid path).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && !full;
  assign pop      = rd_ready && !empty;
  assign count    = wptr - rptr;
  assign rd_data  = mem[rptr[AW-1:0]];

  // Pointer update: reset beats clear, clear beats any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage write; contents are left as-is on reset or clear.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/processor_io_buffer.sv
// Decoupling stage between the user and the network: an input FIFO feeding
// network_source and an output FIFO filled by network_sink. out_afull lets
// the surrounding controller hold the source before the sink backs up.
module processor_io_buffer #(
  parameter int INP_WIDTH = processor_config::INP_WIDTH,
  parameter int OUT_WIDTH = processor_config::OUT_WIDTH,
  parameter int INP_DEPTH = processor_config::INP_DEPTH,
  parameter int OUT_DEPTH = processor_config::OUT_DEPTH,
  parameter int OUT_AFULL = OUT_DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  processor_io_buffer_if.slave   bus
);

  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  if (OUT_AFULL < 1 || OUT_AFULL > OUT_DEPTH) begin : g_bad_afull
    $error("processor_io_buffer: OUT_AFULL must lie in 1..OUT_DEPTH");
  end

  sync_fifo #(
    .WIDTH (INP_WIDTH),
    .DEPTH (INP_DEPTH)
  ) u_inp_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .wr_valid (bus.inp_valid),
    .wr_data  (bus.inp),
    .wr_ready (bus.inp_ready),
    .rd_valid (bus.src_valid),
    .rd_data  (bus.src),
    .rd_ready (bus.src_ready),
    .count    (bus.inp_count)
  );

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .wr_valid (bus.snk_valid),
    .wr_data  (bus.snk),
    .wr_ready (bus.snk_ready),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out),
    .rd_ready (bus.out_ready),
    .count    (bus.out_count)
  );

  // Count comes straight from the pointer registers, so this is registered-state only.
  assign bus.out_afull = (bus.out_count >= OCW'(OUT_AFULL));

endmodule

// File: tb/tb_processor_io_buffer.sv
// Bench for processor_io_buffer: queue-based reference model of both FIFOs,
// directed scenarios plus a randomized run, all compared cycle by cycle.
module tb_processor_io_buffer;
  import processor_config::*;

  localparam int ID = 8;
  localparam int OD = 8;
  localparam int AF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processor_io_buffer_if bus ();

  processor_io_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  inp_pkt_t iq[$];
  out_pkt_t oq[$];

  logic     e_inp_ready, e_src_valid, e_snk_ready, e_out_valid, e_afull;
  inp_pkt_t e_src;
  out_pkt_t e_out;
  int       e_inp_count, e_out_count;

  // Advance one clock and update the model from the inputs presented at the edge.
  task automatic step();
    bit r, f, ip, io, sp, so;
    inp_pkt_t id;
    out_pkt_t od;
    r  = rst;
    f  = bus.flush;
    ip = bus.inp_valid && (iq.size() < ID);
    io = bus.src_ready && (iq.size() > 0);
    sp = bus.snk_valid && (oq.size() < OD);
    so = bus.out_ready && (oq.size() > 0);
    id = bus.inp;
    od = bus.snk;
    @(posedge clk);
    #1;
    if (r || f) begin
      iq.delete();
      oq.delete();
    end else begin
      if (io) void'(iq.pop_front());
      if (ip) iq.push_back(id);
      if (so) void'(oq.pop_front());
      if (sp) oq.push_back(od);
    end
    e_inp_count = iq.size();
    e_out_count = oq.size();
    e_inp_ready = (iq.size() < ID);
    e_snk_ready = (oq.size() < OD);
    e_src_valid = (iq.size() > 0);
    e_out_valid = (oq.size() > 0);
    e_afull     = (oq.size() >= AF);
    e_src       = (iq.size() > 0) ? iq[0] : '0;
    e_out       = (oq.size() > 0) ? oq[0] : '0;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.inp_valid = 1'b0;
    bus.inp       = '0;
    bus.src_ready = 1'b0;
    bus.snk_valid = 1'b0;
    bus.snk       = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({bus.inp_ready, bus.snk_ready, bus.src_valid, bus.out_valid, bus.out_afull} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 11000", {bus.inp_ready, bus.snk_ready, bus.src_valid, bus.out_valid, bus.out_afull});
    end
    checks++;
    if (bus.inp_count !== 4'd0 || bus.out_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.inp_count, bus.out_count);
    end
  endtask

  task automatic test_fill_basic();
    inp_pkt_t vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.inp_valid = 1'b1;
      bus.inp       = vals[i];
      step();
      checks++;
      if (int'(bus.inp_count) !== i + 1 || bus.src_valid !== 1'b1 || bus.src !== 8'h11 || bus.inp_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_basic[%0d]: got count %0d valid %b src %h ready %b want %0d 1 11 1",
                 i, bus.inp_count, bus.src_valid, bus.src, bus.inp_ready, i + 1);
      end
    end
    do_flush();
  endtask

  task automatic test_full_inp();
    inp_pkt_t exp_list[$];
    int k = 0;
    bit accepted = 1'b0;
    idle_inputs();
    for (int i = 0; i < ID; i++) begin
      bus.inp_valid = 1'b1;
      bus.inp       = 8'($urandom);
      exp_list.push_back(bus.inp);
      step();
    end
    bus.inp = 8'hC9;
    exp_list.push_back(bus.inp);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.inp_ready !== 1'b0 || int'(bus.inp_count) !== ID || e_inp_count !== ID) begin
        errors++;
        $display("FAIL full_refuse[%0d]: got ready %b count %0d want 0 %0d", i, bus.inp_ready, bus.inp_count, ID);
      end
    end
    bus.src_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.src_valid && k < exp_list.size()) begin
        checks++;
        if (bus.src !== exp_list[k]) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h want %h", k, bus.src, exp_list[k]);
        end
        k++;
      end
      if (bus.inp_valid && bus.inp_ready) begin
        checks++;
        if (int'(bus.inp_count) !== ID - 1) begin
          errors++;
          $display("FAIL full_accept_point: accepted at count %0d want %0d", bus.inp_count, ID - 1);
        end
        accepted = 1'b1;
      end
      step();
      if (accepted) bus.inp_valid = 1'b0;
      checks++;
      if (int'(bus.inp_count) !== e_inp_count) begin
        errors++;
        $display("FAIL full_count c%0d: got %0d want %0d", c, bus.inp_count, e_inp_count);
      end
    end
    checks++;
    if (k !== ID + 1 || !accepted) begin
      errors++;
      $display("FAIL full_drain_total: got %0d popped accepted %b want %0d 1", k, accepted, ID + 1);
    end
    idle_inputs();
  endtask

  task automatic test_stream();
    int nxt = 0;
    idle_inputs();
    bus.src_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      bus.inp_valid = (c < 20);
      bus.inp       = 8'(c);
      if (c >= 1) begin
        checks++;
        if (bus.src_valid !== 1'b1 || bus.src !== 8'(nxt)) begin
          errors++;
          $display("FAIL stream_pop c%0d: got valid %b src %h want 1 %h", c, bus.src_valid, bus.src, 8'(nxt));
        end
        nxt++;
      end
      step();
      if (c < 20) begin
        checks++;
        if (bus.inp_count !== 4'd1) begin
          errors++;
          $display("FAIL stream_count c%0d: got %0d want 1", c, bus.inp_count);
        end
      end
    end
    checks++;
    if (nxt !== 20 || bus.inp_count !== 4'd0) begin
      errors++;
      $display("FAIL stream_total: got %0d popped count %0d want 20 0", nxt, bus.inp_count);
    end
    idle_inputs();
  endtask

  task automatic test_output();
    out_pkt_t exp_list[$];
    int k = 0;
    idle_inputs();
    for (int i = 0; i < OD; i++) begin
      bus.snk_valid = 1'b1;
      bus.snk       = 8'($urandom);
      exp_list.push_back(bus.snk);
      step();
      checks++;
      if (bus.out_afull !== (i + 1 >= AF) || bus.snk_ready !== (i + 1 < OD) || int'(bus.out_count) !== i + 1) begin
        errors++;
        $display("FAIL out_fill[%0d]: got afull %b ready %b count %0d want %b %b %0d",
                 i, bus.out_afull, bus.snk_ready, bus.out_count, (i + 1 >= AF), (i + 1 < OD), i + 1);
      end
    end
    bus.snk_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid && k < exp_list.size()) begin
        checks++;
        if (bus.out !== exp_list[k]) begin
          errors++;
          $display("FAIL out_order[%0d]: got %h want %h", k, bus.out, exp_list[k]);
        end
        k++;
      end
      step();
    end
    checks++;
    if (k !== OD || bus.out_count !== 4'd0 || bus.out_afull !== 1'b0) begin
      errors++;
      $display("FAIL out_drain_total: got %0d popped count %0d afull %b want %0d 0 0", k, bus.out_count, bus.out_afull, OD);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.inp_valid = 1'b1;
      bus.inp       = 8'($urandom);
      bus.snk_valid = 1'b1;
      bus.snk       = 8'($urandom);
      step();
    end
    checks++;
    if (bus.inp_count !== 4'd4 || bus.out_count !== 4'd4) begin
      errors++;
      $display("FAIL flush_prefill: got %0d/%0d want 4/4", bus.inp_count, bus.out_count);
    end
    bus.flush = 1'b1;
    bus.snk   = 8'hAA;
    bus.inp   = 8'h55;
    step();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.inp_count !== 4'd0 || bus.out_count !== 4'd0 || bus.src_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty[%0d]: got counts %0d/%0d valids %b%b want 0/0 00",
                 i, bus.inp_count, bus.out_count, bus.src_valid, bus.out_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.inp_valid = 1'b1;
      bus.inp       = 8'($urandom);
      bus.snk_valid = 1'b1;
      bus.snk       = 8'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.inp_ready, bus.snk_ready, bus.src_valid, bus.out_valid} !== 4'b1100 ||
        bus.inp_count !== 4'd0 || bus.out_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got flags %b counts %0d/%0d want 1100 0/0",
               {bus.inp_ready, bus.snk_ready, bus.src_valid, bus.out_valid}, bus.inp_count, bus.out_count);
    end
    bus.inp = 8'h5A;
    bus.snk = 8'hA5;
    step();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.inp_count !== 4'd1 || bus.out_count !== 4'd1 || bus.src !== 8'h5A || bus.out !== 8'hA5) begin
        errors++;
        $display("FAIL reset_first_pkt[%0d]: got counts %0d/%0d data %h/%h want 1/1 5a/a5",
                 i, bus.inp_count, bus.out_count, bus.src, bus.out);
      end
      step();
    end
    do_flush();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.inp_valid = ($urandom_range(0, 3) != 0);
      bus.inp       = 8'($urandom);
      bus.src_ready = ($urandom_range(0, 2) == 0);
      bus.snk_valid = ($urandom_range(0, 2) != 0);
      bus.snk       = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if ({bus.inp_ready, bus.src_valid, bus.snk_ready, bus.out_valid, bus.out_afull} !==
          {e_inp_ready, e_src_valid, e_snk_ready, e_out_valid, e_afull} ||
          int'(bus.inp_count) !== e_inp_count || int'(bus.out_count) !== e_out_count) begin
        errors++;
        $display("FAIL rand_status c%0d: got %b %0d/%0d want %b %0d/%0d", c,
                 {bus.inp_ready, bus.src_valid, bus.snk_ready, bus.out_valid, bus.out_afull},
                 bus.inp_count, bus.out_count,
                 {e_inp_ready, e_src_valid, e_snk_ready, e_out_valid, e_afull},
                 e_inp_count, e_out_count);
      end
      if (e_src_valid || e_out_valid) begin
        checks++;
        if ((e_src_valid && bus.src !== e_src) || (e_out_valid && bus.out !== e_out)) begin
          errors++;
          $display("FAIL rand_data c%0d: got %h/%h want %h/%h", c, bus.src, bus.out, e_src, e_out);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_basic();
    test_full_inp();
    test_stream();
    test_output();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_io_buffer.md
Name: processor_io_buffer

Overview:
- Parametrised valid/ready buffering stage that lets a processor run without the "input valid every cycle / output ready every cycle" restriction.
- Input side: user packets land in an input FIFO that feeds network_source through its src_valid/src/src_ready port.
- Output side: network_sink packets land in an output FIFO that drains to the user.
- Both FIFOs have occupancy reporting and a synchronous flush. The surrounding processor stalls the network through the existing source/sink handshakes.

Parameters:
INP_WIDTH, processor_config::INP_WIDTH, input packet width in bits
OUT_WIDTH, processor_config::OUT_WIDTH, output packet width in bits
INP_DEPTH, 8, input FIFO entries; power of two, >= 2
OUT_DEPTH, 8, output FIFO entries; power of two, >= 2
OUT_AFULL, OUT_DEPTH-2, output almost-full threshold; 1 <= OUT_AFULL <= OUT_DEPTH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
flush  input  1  synchronous clear of both FIFOs; one-cycle pulse
inp_valid  input  1  user input packet valid
inp  input  INP_WIDTH  user input packet
inp_ready  output  1  input FIFO can accept
src_valid  output  1  packet available to network_source
src  output  INP_WIDTH  head of input FIFO
src_ready  input  1  network_source consumes head
snk_valid  input  1  network_sink presents packet
snk  input  OUT_WIDTH  network_sink packet
snk_ready  output  1  output FIFO can accept
out_valid  output  1  packet available to user
out  output  OUT_WIDTH  head of output FIFO
out_ready  input  1  user consumes head
inp_count  output  $clog2(INP_DEPTH)+1  input FIFO occupancy
out_count  output  $clog2(OUT_DEPTH)+1  output FIFO occupancy
out_afull  output  1  out_count >= OUT_AFULL

Behaviour:
- Transfer rule on every interface: a transfer occurs only in a cycle where valid && ready at the rising edge.
  - No valid may depend combinationally on the same interface's ready.
  - Data must stay stable while valid && !ready.
- Each FIFO:
  - Storage is a register array.
  - Read and write pointers are $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - Empty when pointers are equal. Full when the low bits are equal and the MSBs differ.
  - count = wptr - rptr, computed modulo 2^(clog2+1).
- States per FIFO: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). These are derived from count; no separate state register.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop at count=DEPTH-1.
  - FULL -> PARTIAL on pop.
  - PARTIAL -> EMPTY on pop without push at count=1.
- inp_ready = !inp_full and snk_ready = !out_full, both from registered state only.
  - A push at FULL is refused even when a pop happens in the same cycle. This avoids a ready->valid combinational path.
- src_valid = !inp_empty and out_valid = !out_empty.
  - src and out are driven from mem[rptr] (the head entry).
- Latency: a packet written at edge N is visible on src/out with valid high after edge N (first-word-fall-through, 1 cycle). There is no bypass path.
- Simultaneous push and pop in PARTIAL: both pointers advance and count is unchanged.
  - Simultaneous push and pop in EMPTY: only the push is possible, since valid is low.
- Pointer wrap-around: the low bits index the memory modulo DEPTH. The MSB toggles each pass. Data ordering is preserved across the wrap.
- flush: in the cycle after flush=1, both FIFOs are EMPTY and counts are 0. A transfer presented in the flush cycle is discarded.
  - Memory contents need not be cleared.
- rst (also mid-transfer): all pointers are 0 after the edge.
  - Outputs after reset: inp_ready=1, snk_ready=1, src_valid=0, out_valid=0, inp_count=0, out_count=0.
  - out_afull = (OUT_AFULL==0) = 0.
  - src and out are don't-care; the bench checks them only when valid.
- rst takes priority over flush. flush takes priority over push/pop.
- out_afull is registered-state derived. It lets the surrounding controller hold the source before sink backpressure.
- Elaboration assertions:
  - DEPTH is a power of two and >= 2.
  - OUT_AFULL is within range.
  - Widths are >= 1.

Decomposition:
- processor_config package:
  - INP_WIDTH and OUT_WIDTH stay there.
  - Add localparam defaults INP_DEPTH/OUT_DEPTH.
  - Add packet typedefs inp_pkt_t = logic [INP_WIDTH-1:0] and out_pkt_t = logic [OUT_WIDTH-1:0].
- One sub-module, sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports clk, rst, clr, wr_valid/wr_data/wr_ready, rd_valid/rd_data/rd_ready, count.
- processor_io_buffer instantiates sync_fifo twice and adds out_afull logic. Target about 150 lines including sync_fifo.

Test Plan:
- Reset, then push 8'h11, 8'h22, 8'h33 on inp with src_ready=0 -> inp_count 1,2,3. src_valid=1 and src=8'h11 one cycle after the first push. inp_ready stays 1.
- INP_DEPTH=8, push 8 packets with src_ready=0, then try a 9th -> inp_ready=0 at count 8 and the 9th is not accepted. Then raise src_ready with inp_valid held -> the 9th is accepted only after a pop frees a slot, and order is preserved.
- Stream 20 packets 0..19 with inp_valid=1 and src_ready=1 continuously -> a src transfer every cycle after a 1-cycle fill. Sequence is 0..19 across two pointer wraps. inp_count stays at 1.
- Output side, OUT_DEPTH=8, OUT_AFULL=6, out_ready=0, push 6 snk packets -> out_afull rises the cycle after the 6th push. snk_ready=0 after the 8th. out_ready=1 then drains in order.
- Fill both FIFOs with 4 entries, pulse flush together with snk_valid=1 -> next cycle counts are 0, valids are 0, and the flush-cycle packet is lost.
- Assert rst mid-stream with inp_valid=1 and snk_valid=1 -> after the edge all counts are 0, src_valid=0, out_valid=0, inp_ready=1, snk_ready=1. The first post-reset packet appears alone.
